// File: rtl/vr_multi_loader.sv
// vr_multi_loader: keeps NUM_CH digital-pot wiper channels in sync with their
// parallel inputs over a 3-wire serial link (sclk, cs_n, sdi).
// Every channel is written after reset, after shutdown, and on refresh_i;
// otherwise a channel is rewritten only when its input differs from the last
// value sent. Channels are served round-robin starting after ch_o.
//
// Optional build macro: VR_SCLK_GATE_EN
//   defined   -> sclk_o is held low outside SHIFT
//   undefined -> sclk_o runs continuously (legacy free-running wiring)
//
// state  | meaning
// IDLE   | link quiet, waiting for a dirty channel and a falling tick
// SHIFT  | cs_n low, FRAME_W bits shifted MSB first, one bit per sclk period
// HOLD   | cs_n high gap of CS_GAP sclk periods after a frame
// SHDN   | device shut down, any frame aborted, all channels marked for rewrite
module vr_multi_loader #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int CLK_DIV = 1,
  parameter int CS_GAP  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       chip_en_i,
  input  logic                       refresh_i,
  input  logic [NUM_CH*DATA_W-1:0]   val_i,
  output logic                       shdn_n_o,
  output logic                       cs_n_o,
  output logic                       sdi_o,
  output logic                       sclk_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [ADDR_W-1:0]          ch_o
);

  localparam int FRAME_W     = ADDR_W + DATA_W;
  localparam int SHIFT_TICKS = 2 * FRAME_W;
  localparam int HOLD_TICKS  = 2 * CS_GAP;
  localparam int CNT_MAX     = (SHIFT_TICKS > HOLD_TICKS) ? SHIFT_TICKS : HOLD_TICKS;
  localparam int CNT_W       = $clog2(CNT_MAX);
  localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_SHDN  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sclk_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               sdi_q, sdi_d;
  logic               cs_n_q, cs_n_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               shdn_n_q, shdn_n_d;
  logic [ADDR_W-1:0]  ch_q, ch_d;
  logic [NUM_CH-1:0]  force_q, force_d;
  logic [DATA_W-1:0]  shadow_q [NUM_CH];
  logic [DATA_W-1:0]  shadow_d [NUM_CH];

  logic               tick;
  logic               fall;
  logic [NUM_CH-1:0]  dirty;
  logic               can_start;
  logic               start;
  logic               sel_found;
  logic [ADDR_W-1:0]  sel_ch;
  logic [DATA_W-1:0]  sel_val;

  // a tick fires whenever the down-counting divider reaches zero
  assign tick = (div_q == '0);
  assign fall = tick & sclk_q;
  assign div_d = tick ? DIV_W'(CLK_DIV - 1) : (div_q - DIV_W'(1));

  // free-running divider and serial clock phase
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      if (tick) sclk_q <= ~sclk_q;
    end
  end

  // a channel needs a write when its input moved or it was forced
  always_comb begin
    dirty = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      dirty[k] = (val_i[k*DATA_W +: DATA_W] != shadow_q[k]) | force_q[k];
    end
  end

  assign can_start = chip_en_i & (|dirty);

  // round-robin pick: lowest dirty channel above ch_q, else lowest dirty overall
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (dirty[k] && (k > int'(ch_q))) begin
        sel_ch    = ADDR_W'(k);
        sel_found = 1'b1;
      end
    end
    if (!sel_found) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (dirty[k]) sel_ch = ADDR_W'(k);
      end
    end
    sel_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_ch == ADDR_W'(k)) sel_val = val_i[k*DATA_W +: DATA_W];
    end
  end

  // sequencing FSM; shutdown overrides everything else
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    sdi_d    = sdi_q;
    cs_n_d   = cs_n_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    shdn_n_d = shdn_n_q;
    ch_d     = ch_q;
    start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall && can_start) start = 1'b1;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (cnt_q == '0) begin
            state_d = ST_HOLD;
            cs_n_d  = 1'b1;
            sdi_d   = 1'b0;
            done_d  = 1'b1;
            cnt_d   = CNT_W'(HOLD_TICKS - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (sclk_q) begin
              sdi_d = sr_q[FRAME_W-1];
              sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (cnt_q == '0) begin
            // back-to-back frames skip IDLE so the frame period stays fixed
            if (can_start) begin
              start = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_SHDN: begin
        if (chip_en_i) begin
          state_d  = ST_IDLE;
          shdn_n_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_SHIFT;
      cs_n_d  = 1'b0;
      busy_d  = 1'b1;
      ch_d    = sel_ch;
      sdi_d   = sel_ch[ADDR_W-1];
      sr_d    = {sel_ch, sel_val} << 1;
      cnt_d   = CNT_W'(SHIFT_TICKS - 1);
    end
    if (!chip_en_i) begin
      state_d  = ST_SHDN;
      shdn_n_d = 1'b0;
      cs_n_d   = 1'b1;
      sdi_d    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  // snapshot on frame start; refresh and shutdown win over the start clear
  always_comb begin
    force_d  = force_q;
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (start && (sel_ch == ADDR_W'(k))) begin
        shadow_d[k] = val_i[k*DATA_W +: DATA_W];
        force_d[k]  = 1'b0;
      end
      if (refresh_i || !chip_en_i) force_d[k] = 1'b1;
    end
  end

  // FSM and per-channel tracking registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      sdi_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      shdn_n_q <= 1'b1;
      ch_q     <= ADDR_W'(NUM_CH - 1);
      force_q  <= '1;
      for (int k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      sdi_q    <= sdi_d;
      cs_n_q   <= cs_n_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      shdn_n_q <= shdn_n_d;
      ch_q     <= ch_d;
      force_q  <= force_d;
      for (int k = 0; k < NUM_CH; k++) shadow_q[k] <= shadow_d[k];
    end
  end

`ifdef VR_SCLK_GATE_EN
  // sclk_q and state_q change on the same falling tick, so the gate is glitch-free
  assign sclk_o = sclk_q & (state_q == ST_SHIFT);
`else
  assign sclk_o = sclk_q;
`endif

  assign shdn_n_o = shdn_n_q;
  assign cs_n_o   = cs_n_q;
  assign sdi_o    = sdi_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign ch_o     = ch_q;

endmodule
